kab_io_bus_initiator: RTL
=========================

// Module: kab_io_bus_initiator
// PURPOSE
//  Processor-side initiator for the Kab I/O register bus and the external interrupt handshake.
//  Converts one-at-a-time load/store requests into single-cycle Sys_WrEn/Sys_RdEn strobes.
//  Captures Sys_RdData after a fixed read latency and returns a one-cycle response.
//  Turns EIC_IntReq into a CPU-visible pending flag and returns a one-cycle EIC_IntAck when the CPU takes it.
// PARAMETERS
//  RD_LATENCY  1  cycles from the Sys_RdEn cycle to the cycle in which Sys_RdData is valid; legal range 1..4
// PORTS
//  Sys_Clock       in   1   single clock
//  Sys_Reset       in   1   asynchronous, active-low reset
//  Req_Valid       in   1   CPU access request valid
//  Req_Ready       out  1   initiator can accept a request
//  Req_Write       in   1   1 = store, 0 = load
//  Req_Address     in   30  word address
//  Req_WrData      in   32  store data
//  Rsp_Valid       out  1   one-cycle completion pulse; no backpressure
//  Rsp_RdData      out  32  load data, valid while Rsp_Valid is high; 0 for stores
//  Sys_WrData      out  32  I/O bus write data
//  Sys_Address     out  30  I/O bus word address
//  Sys_WrEn        out  1   I/O bus write strobe
//  Sys_RdEn        out  1   I/O bus read strobe
//  Sys_RdData      in   32  I/O bus read data
//  EIC_IntReq      in   1   level interrupt request from the external interrupt controller
//  EIC_IntId       in   1   interrupt identity
//  EIC_IntAck      out  1   one-cycle acknowledge
//  Cpu_IntPending  out  1   interrupt pending, visible to the CPU
//  Cpu_IntId       out  1   identity latched at take
//  Cpu_IntTake     in   1   CPU accepts the pending interrupt
// BEHAVIOUR
//  Reset (Sys_Reset=0, asynchronous)
//   - FSM goes to IDLE.
//   - All outputs are 0 except Req_Ready, which is 1.
//   - An access in flight is aborted; no Rsp_Valid is issued for it.
//  Bus FSM: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE
//   - IDLE: Req_Ready=1 (decoded from state). Req_Valid&&Req_Ready at a rising edge latches Req_* and moves to ACCESS.
//   - ACCESS (exactly one cycle, Req_Ready=0):
//     - Sys_Address=latched address.
//     - Store: Sys_WrEn=1, Sys_WrData=latched data; next state RESP.
//     - Load: Sys_RdEn=1; next state WAIT with counter=RD_LATENCY.
//   - WAIT: counter decrements each cycle. In the cycle where counter==1 (cycle ACCESS+RD_LATENCY), Sys_RdData is registered into Rsp_RdData and the FSM moves to RESP.
//   - RESP: Rsp_Valid=1 for one cycle, then IDLE. Rsp_RdData=0 for stores. Rsp_RdData holds its value until the next response.
//  Bus outputs
//   - Sys_WrEn, Sys_RdEn, Sys_Address and Sys_WrData are registered.
//   - They are 0 in every state other than ACCESS.
//   - Sys_WrEn and Sys_RdEn are never both 1.
//  Latency
//   - Store: accept edge to Rsp_Valid = 2 cycles.
//   - Load: accept edge to Rsp_Valid = RD_LATENCY+2 cycles.
//   - Next accept is possible in the cycle after RESP.
//  Req_Valid held high: a new request is accepted on every return to IDLE; no request is lost or duplicated.
//  Interrupt path (independent of the bus FSM; both run concurrently)
//   - Cpu_IntPending = registered EIC_IntReq, masked while the ack is in progress.
//   - Cpu_IntTake while Cpu_IntPending=1:
//     - Cpu_IntId<=EIC_IntId.
//     - EIC_IntAck=1 for exactly the next cycle.
//     - Cpu_IntPending is forced to 0 for that cycle and the one after, so the controller can drop or re-evaluate its request.
//   - Cpu_IntTake while Cpu_IntPending=0 is ignored: no ack, Cpu_IntId unchanged.
//   - EIC_IntReq dropping before take: Cpu_IntPending falls one cycle later; no ack.
// TESTING
//  - Store: Req addr=0x0000010, data=0xDEADBEEF -> one cycle of WrEn=1 with that addr/data; Rsp_Valid 2 cycles after accept; Rsp_RdData=0.
//  - Load, RD_LATENCY=1: responder returns 0x12345678 -> RdEn for one cycle; Rsp_Valid 3 cycles after accept with Rsp_RdData=0x12345678.
//  - Load, RD_LATENCY=3: responder drives 0xA5A5A5A5 only in cycle ACCESS+3 -> captured; Rsp_Valid at accept+5.
//  - Req_Valid held high for 3 mixed requests -> exactly 3 strobes, 3 Rsp_Valid pulses, in order; Req_Ready=1 only in IDLE.
//  - EIC_IntReq=1, EIC_IntId=1, then Cpu_IntTake -> EIC_IntAck high for one cycle; Cpu_IntId=1; Cpu_IntPending low for 2 cycles. A take with no request pending -> no ack.
//  - Sys_Reset low during WAIT -> strobes and Rsp_Valid are 0 immediately; after release, Req_Ready=1 and no stale response appears.

Source files
------------

// File: rtl/kab_io_bus_initiator.sv
// kab_io_bus_initiator
// Processor-side initiator for the Kab I/O register bus. Single-outstanding
// load/store requests become one-cycle Sys_WrEn/Sys_RdEn strobes, read data
// is captured RD_LATENCY cycles after the read strobe and returned as a
// one-cycle response. An independent path turns EIC_IntReq into a
// CPU-visible pending flag and issues EIC_IntAck when the CPU takes it.
module kab_io_bus_initiator #(
  parameter int unsigned RD_LATENCY = 1  // legal range 1..4
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [29:0] Req_Address,
  input  logic [31:0] Req_WrData,
  output logic        Rsp_Valid,
  output logic [31:0] Rsp_RdData,
  output logic [31:0] Sys_WrData,
  output logic [29:0] Sys_Address,
  output logic        Sys_WrEn,
  output logic        Sys_RdEn,
  input  logic [31:0] Sys_RdData,
  input  logic        EIC_IntReq,
  input  logic        EIC_IntId,
  output logic        EIC_IntAck,
  output logic        Cpu_IntPending,
  output logic        Cpu_IntId,
  input  logic        Cpu_IntTake
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_wren;
  logic        r_rden;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_data;

  logic        r_int_pend;
  logic        r_int_ack;
  logic        r_int_id;
  logic        w_int_take;

  // Bus FSM. The Sys_* registers double as the request latch: they are loaded
  // at the accept edge so they are valid exactly during ACCESS and cleared
  // on every other edge.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_wren  <= 1'b0;
      r_rden  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (Req_Valid) begin
            r_state <= ST_ACCESS;
            r_wren  <= Req_Write;
            r_rden  <= !Req_Write;
            r_addr  <= Req_Address;
            r_wdata <= Req_Write ? Req_WrData : '0;
          end
        end
        ST_ACCESS: begin
          if (r_wren) begin
            r_state    <= ST_RESP;
            r_rsp_data <= '0;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= 3'(RD_LATENCY);
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_rsp_data <= Sys_RdData;
            r_state    <= ST_RESP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_int_take = Cpu_IntTake && r_int_pend;

  // Interrupt path. Pending is masked in the take-accept cycle and the ack
  // cycle that follows, giving the controller two cycles to drop its request.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_int_pend <= 1'b0;
      r_int_ack  <= 1'b0;
      r_int_id   <= 1'b0;
    end else begin
      r_int_pend <= EIC_IntReq && !w_int_take && !r_int_ack;
      r_int_ack  <= w_int_take;
      if (w_int_take) begin
        r_int_id <= EIC_IntId;
      end
    end
  end

  assign Req_Ready      = (r_state == ST_IDLE);
  assign Rsp_Valid      = (r_state == ST_RESP);
  assign Rsp_RdData     = r_rsp_data;
  assign Sys_WrEn       = r_wren;
  assign Sys_RdEn       = r_rden;
  assign Sys_Address    = r_addr;
  assign Sys_WrData     = r_wdata;
  assign EIC_IntAck     = r_int_ack;
  assign Cpu_IntPending = r_int_pend;
  assign Cpu_IntId      = r_int_id;

endmodule
